// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Avalon-MM slave that drives a 6-digit multiplexed 7-segment display and
// debounces four active-low push buttons.
//
// Each digit owns one time slot of SCAN_DIV cycles. The first BLANK_CYCLES
// cycles of every slot keep all digits dark so the previous digit's segment
// charge cannot ghost onto the next one. Button presses are synchronised,
// debounced, and their rising edges are latched for software to poll and
// clear with write-1-to-clear.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   address[2:0]      word address: 0-5 DIGITn, 6 CTRL, 7 BTN
//   write, writedata  write strobe and data
//   read, readdata    read strobe; readdata is registered (1-cycle latency)
//                     and held until the next read
//   nButton[3:0]      raw buttons, active-low, asynchronous to clk
//   LedButton[3:0]    debounced button state, high = pressed
//   nSelDig[5:0]      digit enables, active-low
//   SelSeg[7:0]       segment drive, active-high, bit7 = decimal point
//   Reset_Led         high while scanning is disabled
//
// Register map:
//   0-5 DIGITn  [7:0]  segment pattern of digit n
//   6   CTRL    [0] EN, [13:8] MASK (1 = digit dark, slot still consumed)
//   7   BTN     read: [3:0] debounced state, [11:8] edge flags
//               write: 1 in [11:8] clears the matching edge flag
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,  // cycles per digit slot, >= 2
    parameter int BLANK_CYCLES = 500,    // dark cycles at slot start, < SCAN_DIV
    parameter int DEBOUNCE     = 500000  // stable cycles to accept a change, >= 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic [3:0]  nButton,
    output logic [3:0]  LedButton,
    output logic [5:0]  nSelDig,
    output logic [7:0]  SelSeg,
    output logic        Reset_Led
);

    localparam int NUM_DIG = 6;
    localparam int PW      = $clog2(SCAN_DIV);
    localparam int CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_START = PW'(BLANK_CYCLES);
    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NUM_DIG-1:0][7:0] digit_q, digit_d;
    logic                    en_q, en_d;
    logic [NUM_DIG-1:0]      mask_q, mask_d;

    logic [PW-1:0]           presc_q, presc_d;
    logic [2:0]              idx_q, idx_d;

    logic [NUM_DIG-1:0]      nsel_q, nsel_d;
    logic [7:0]              seg_q, seg_d;
    logic                    rstled_q, rstled_d;
    logic [31:0]             rdata_q, rdata_d;

    logic [3:0]              sync1_q, sync1_d;
    logic [3:0]              sync2_q, sync2_d;
    logic [3:0]              deb_q, deb_d;
    logic [3:0]              edge_q, edge_d;
    logic [3:0][CW-1:0]      cnt_q, cnt_d;

    logic [3:0]              btn_clr;
    logic [3:0]              raw;
    logic                    lit;

    // -----------------------------------------------------------------------
    // Register file writes
    // -----------------------------------------------------------------------
    always_comb begin
        digit_d = digit_q;
        en_d    = en_q;
        mask_d  = mask_q;
        btn_clr = 4'd0;
        if (write) begin
            for (int n = 0; n < NUM_DIG; n++) begin
                if (address == 3'(n)) digit_d[n] = writedata[7:0];
            end
            if (address == 3'd6) begin
                en_d   = writedata[0];
                mask_d = writedata[13:8];
            end
            if (address == 3'd7) btn_clr = writedata[11:8];
        end
    end

    // -----------------------------------------------------------------------
    // Read path: samples the pre-write register values, so a read and a
    // write to the same address in one cycle returns the old contents.
    // -----------------------------------------------------------------------
    always_comb begin
        rdata_d = rdata_q;
        if (read) begin
            rdata_d = 32'd0;
            for (int n = 0; n < NUM_DIG; n++) begin
                if (address == 3'(n)) rdata_d = {24'd0, digit_q[n]};
            end
            if (address == 3'd6) rdata_d = {18'd0, mask_q, 7'd0, en_q};
            if (address == 3'd7) rdata_d = {20'd0, edge_q, 4'd0, deb_q};
        end
    end

    // -----------------------------------------------------------------------
    // Scan timing: prescaler and digit index. Held at zero while disabled so
    // that enabling always restarts at digit 0, prescaler 0.
    // -----------------------------------------------------------------------
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (!en_q) begin
            presc_d = '0;
            idx_d   = 3'd0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Display outputs, registered one cycle behind the scan state. The
    // digit select is built one-hot from the index, so at most one enable is
    // ever active.
    // -----------------------------------------------------------------------
    always_comb begin
        lit = 1'b0;
        for (int n = 0; n < NUM_DIG; n++) begin
            if (idx_q == 3'(n)) lit = en_q && (presc_q >= BLANK_START) && !mask_q[n];
        end

        nsel_d = {NUM_DIG{1'b1}};
        seg_d  = 8'd0;
        if (lit) begin
            for (int n = 0; n < NUM_DIG; n++) begin
                if (idx_q == 3'(n)) begin
                    nsel_d[n] = 1'b0;
                    seg_d     = digit_q[n];
                end
            end
        end
        rstled_d = ~en_q;
    end

    // -----------------------------------------------------------------------
    // Buttons: two-flop synchroniser, per-button debounce counter, edge
    // flags. The counter measures consecutive cycles in which the
    // synchronised level disagrees with the accepted state; any agreement
    // restarts it, so short glitches never get through.
    // -----------------------------------------------------------------------
    assign sync1_d = nButton;
    assign sync2_d = sync1_q;
    assign raw     = ~sync2_q;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            if (raw[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                deb_d[i] = ~deb_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        // A new press in the same cycle as a clear must not be lost.
        edge_d = (edge_q & ~btn_clr) | (deb_d & ~deb_q);
    end

    // -----------------------------------------------------------------------
    // Flops
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_q  <= '0;
            en_q     <= 1'b0;
            mask_q   <= '0;
            presc_q  <= '0;
            idx_q    <= 3'd0;
            nsel_q   <= {NUM_DIG{1'b1}};
            seg_q    <= 8'd0;
            rstled_q <= 1'b1;
            rdata_q  <= 32'd0;
            // Synchronisers start at the released (idle-high) level so the
            // debouncer never sees a phantom press coming out of reset.
            sync1_q  <= 4'hF;
            sync2_q  <= 4'hF;
            deb_q    <= 4'd0;
            edge_q   <= 4'd0;
            cnt_q    <= '0;
        end else begin
            digit_q  <= digit_d;
            en_q     <= en_d;
            mask_q   <= mask_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            nsel_q   <= nsel_d;
            seg_q    <= seg_d;
            rstled_q <= rstled_d;
            rdata_q  <= rdata_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            edge_q   <= edge_d;
            cnt_q    <= cnt_d;
        end
    end

    assign readdata  = rdata_q;
    assign LedButton = deb_q;
    assign nSelDig   = nsel_q;
    assign SelSeg    = seg_q;
    assign Reset_Led = rstled_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Scoreboard bench for seg7_scan_ctrl. A reference model advances on each
// clock edge, pushing the expected display/button outputs and any expected
// read data into queues; a monitor on the falling edge pops and compares.
// The model describes the scan as "cycles since enable" divided into slots
// and the debouncer as "the last DEBOUNCE samples all disagree".
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int SD = 8;
    localparam int BL = 2;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic [3:0]  nButton = 4'hF;
    logic [3:0]  LedButton;
    logic [5:0]  nSelDig;
    logic [7:0]  SelSeg;
    logic        Reset_Led;

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BL), .DEBOUNCE(DB)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .nButton(nButton), .LedButton(LedButton), .nSelDig(nSelDig),
        .SelSeg(SelSeg), .Reset_Led(Reset_Led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    logic [31:0] disp_q[$];
    logic [31:0] rd_q[$];

    logic [7:0]  m_dig[6];
    logic        m_en;
    logic [5:0]  m_mask;
    int          m_t;        // cycles elapsed since scanning was enabled
    logic [3:0]  m_s1, m_s2;
    logic [3:0]  m_deb, m_edge;
    logic [31:0] m_hist[4];  // recent raw samples, newest in bit 0

    task automatic m_reset();
        for (int n = 0; n < 6; n++) m_dig[n] = 8'd0;
        m_en = 1'b0; m_mask = 6'd0; m_t = 0;
        m_s1 = 4'hF; m_s2 = 4'hF;
        m_deb = 4'd0; m_edge = 4'd0;
        for (int i = 0; i < 4; i++) m_hist[i] = 32'd0;
        disp_q.delete();
        rd_q.delete();
    endtask

    task automatic model_step();
        int          slot, ph;
        logic        lit, e_rst;
        logic [5:0]  e_nsel;
        logic [7:0]  e_seg;
        logic [3:0]  raw, nd, rise, w1c;
        logic [31:0] win, full;

        slot   = (m_t / SD) % 6;
        ph     = m_t % SD;
        lit    = m_en && (ph >= BL) && !m_mask[slot];
        e_nsel = 6'h3F;
        e_seg  = 8'd0;
        if (lit) begin
            e_nsel[slot] = 1'b0;
            e_seg        = m_dig[slot];
        end
        e_rst = ~m_en;

        if (read) begin
            if (address < 3'd6)       rd_q.push_back({24'd0, m_dig[address]});
            else if (address == 3'd6) rd_q.push_back({18'd0, m_mask, 7'd0, m_en});
            else                      rd_q.push_back({20'd0, m_edge, 4'd0, m_deb});
        end

        raw  = ~m_s2;
        m_s2 = m_s1;
        m_s1 = nButton;
        full = 32'((1 << DB) - 1);
        nd   = m_deb;
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = {m_hist[i][30:0], raw[i]};
            win = m_hist[i] & full;
            if (m_deb[i] ? (win == 32'd0) : (win == full)) nd[i] = ~m_deb[i];
        end
        rise   = nd & ~m_deb;
        w1c    = (write && address == 3'd7) ? writedata[11:8] : 4'd0;
        m_edge = (m_edge & ~w1c) | rise;
        m_deb  = nd;

        m_t = m_en ? m_t + 1 : 0;
        if (write) begin
            if (address < 3'd6) m_dig[address] = writedata[7:0];
            else if (address == 3'd6) begin
                m_en   = writedata[0];
                m_mask = writedata[13:8];
            end
        end

        disp_q.push_back({13'd0, e_nsel, e_seg, m_deb, e_rst});
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) m_reset();
            else          model_step();
        end
    end

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    initial begin
        logic [31:0] exp_v;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (disp_q.size() > 0) begin
                    exp_v = disp_q.pop_front();
                    chk("display", {13'd0, nSelDig, SelSeg, LedButton, Reset_Led}, exp_v);
                    chk("one_digit_max", 32'($countones(~nSelDig) <= 1), 32'd1);
                end
                if (rd_q.size() > 0) begin
                    exp_v = rd_q.pop_front();
                    chk("readdata", readdata, exp_v);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
        write = w; read = r; address = a; writedata = d;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        bus(1'b0, 1'b1, a, 32'd0);
    endtask

    initial begin
        logic [7:0] pat [6];
        logic       found;
        pat[0] = 8'h3F; pat[1] = 8'h06; pat[2] = 8'h5B;
        pat[3] = 8'h4F; pat[4] = 8'h66; pat[5] = 8'h6D;

        // Power-on reset
        #2 reset_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_nsel", 32'(nSelDig), 32'h3F);
        chk("rst_seg", 32'(SelSeg), 32'h0);
        chk("rst_led", 32'(Reset_Led), 32'h1);
        chk("rst_btn", 32'(LedButton), 32'h0);
        chk("rst_rdata", readdata, 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        rd(3'd6);
        rd(3'd7);

        // Scan of six digits
        for (int n = 0; n < 6; n++) wr(3'(n), {24'd0, pat[n]});
        wr(3'd6, 32'h1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("slot0_nsel", 32'(nSelDig), (k < 2) ? 32'h3F : 32'h3E);
            chk("slot0_seg", 32'(SelSeg), (k < 2) ? 32'h0 : 32'h3F);
        end
        idle(60);

        // Mask digit 2
        wr(3'd6, 32'h0401);
        idle(60);

        // Disable in the middle of digit 4
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_en && ((m_t / SD) % 6) == 4 && (m_t % SD) == 4) found = 1'b1;
            else idle(1);
        end
        chk("wait_digit4", 32'(found), 32'h1);
        wr(3'd6, 32'h0);
        @(posedge clk); #1;
        chk("dis_nsel", 32'(nSelDig), 32'h3F);
        chk("dis_seg", 32'(SelSeg), 32'h0);
        chk("dis_rstled", 32'(Reset_Led), 32'h1);
        idle(10);
        wr(3'd6, 32'h1);
        idle(20);

        // Glitch shorter than the debounce window
        nButton[1] = 1'b0;
        idle(3);
        nButton[1] = 1'b1;
        idle(10);
        chk("glitch_btn", 32'(LedButton), 32'h0);

        // Held press: accepted 2 + DEBOUNCE cycles after the fall
        nButton[1] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 5) chk("press_early", 32'(LedButton[1]), 32'h0);
            if (k == 6) chk("press_at6", 32'(LedButton), 32'h2);
        end
        rd(3'd7);
        chk("btn_read", readdata, 32'h0000_0202);

        // W1C, then clear colliding with a new press of button 3
        wr(3'd7, 32'h200);
        rd(3'd7);
        chk("w1c_read", readdata, 32'h0000_0002);
        nButton[3] = 1'b0;
        idle(5);
        wr(3'd7, 32'h800);
        rd(3'd7);
        chk("set_wins", readdata, 32'h0000_080A);

        // Read and write of the same register in one cycle
        bus(1'b1, 1'b1, 3'd3, 32'h0000_00A5);
        chk("rw_old", readdata, 32'h0000_004F);
        rd(3'd3);
        chk("rw_new", readdata, 32'h0000_00A5);

        // Random traffic
        nButton = 4'hF;
        for (int c = 0; c < 800; c++) begin
            int r;
            logic [2:0]  a;
            logic [31:0] d;
            if ($urandom_range(0, 11) == 0) nButton[$urandom_range(0, 3)] ^= 1'b1;
            r = $urandom_range(0, 9);
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd6) d[0] = ($urandom_range(0, 3) != 0);
            if (r < 2)       bus(1'b1, 1'b0, a, d);
            else if (r == 2) bus(1'b0, 1'b1, a, d);
            else if (r == 3) bus(1'b1, 1'b1, a, d);
            else             idle(1);
        end

        // Asynchronous reset in the middle of a scan with a button held
        wr(3'd6, 32'h1);
        nButton = 4'b1110;
        idle(20);
        #3 reset_n = 1'b0;
        #1;
        chk("amid_nsel", 32'(nSelDig), 32'h3F);
        chk("amid_seg", 32'(SelSeg), 32'h0);
        chk("amid_rstled", 32'(Reset_Led), 32'h1);
        chk("amid_btn", 32'(LedButton), 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        rd(3'd6);
        chk("post_rst_ctrl", readdata, 32'h0);
        rd(3'd7);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
